sram_word_bridge: RTL

SRAM_WORD_BRIDGE -- requirements
Module: sram_word_bridge

---
 rtl/sram_word_bridge.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sram_word_bridge.sv
// sram_word_bridge: converts one CPU byte/halfword/word request into a sequence of
// 16-bit SRAM transfers and returns a single completion response.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid / req_ready     CPU request handshake (ready only while idle)
//   req_rw, req_size          1 = write; size 00 byte, 01 half, 10 word, 11 illegal
//   req_addr, req_wdata       byte address, right-aligned little-endian write data
//   resp_valid                one-cycle completion pulse
//   resp_err, resp_rdata      error flag and read data, qualified by resp_valid
//   sram_valid                one-cycle transfer-start pulse
//   sram_rw, sram_addr        transfer direction and byte address (held per beat)
//   sram_dtw                  transfer write data (held per beat)
//   sram_dtr, sram_done       transfer read data and one-cycle completion pulse
module sram_word_bridge (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        sram_valid,
    output logic        sram_rw,
    output logic [31:0] sram_addr,
    output logic [15:0] sram_dtw,
    input  logic [15:0] sram_dtr,
    input  logic        sram_done
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic        rw_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  k_q;
    logic [15:0] rbuf_q;  // halfword 0 of a word read; halfword 1 arrives with the final done

    logic        accept;
    logic        req_bad;
    logic        beat_done;
    logic        last_beat;
    logic [2:0]  k_next;
    logic [2:0]  nbeats;
    logic [31:0] rdata_final;

    // Writes go out one byte per beat; reads fetch a halfword per beat.
    function automatic logic [2:0] beat_count(input logic rw, input logic [1:0] size);
        case ({rw, size})
            3'b0_00: return 3'd1;
            3'b0_01: return 3'd1;
            3'b0_10: return 3'd2;
            3'b1_00: return 3'd1;
            3'b1_01: return 3'd2;
            3'b1_10: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic rw,
                                              input logic [2:0] k);
        return rw ? base + {29'd0, k} : base + {28'd0, k, 1'b0};
    endfunction

    // Write beats replicate the byte on both lanes so the SRAM can use either.
    function automatic logic [15:0] beat_dtw(input logic rw, input logic [31:0] wdata,
                                             input logic [2:0] k);
        logic [7:0] b;
        b = wdata[{k[1:0], 3'b000} +: 8];
        return rw ? {b, b} : 16'h0000;
    endfunction

    assign accept    = (state_q == StIdle) && req_valid;
    assign req_bad   = (req_size == 2'b11)
                     || ((req_size == 2'b01) && req_addr[0])
                     || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign beat_done = (state_q == StWait) && sram_done;
    assign k_next    = k_q + 3'd1;
    assign nbeats    = beat_count(rw_q, size_q);
    assign last_beat = (k_next >= nbeats);

    // Read result assembled from the beat completing now.
    always_comb begin
        rdata_final = 32'h0;
        if (!rw_q) begin
            case (size_q)
                2'b00:   rdata_final = {24'h0, addr_q[0] ? sram_dtr[15:8] : sram_dtr[7:0]};
                2'b01:   rdata_final = {16'h0, sram_dtr};
                2'b10:   rdata_final = {sram_dtr, rbuf_q};
                default: rdata_final = 32'h0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = req_bad ? StResp : StIssue;
            StIssue: state_d = StWait;
            StWait:  if (sram_done) state_d = last_beat ? StResp : StIssue;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        req_ready  = (state_q == StIdle);
        sram_valid = (state_q == StIssue);
        resp_valid = (state_q == StResp);
    end

    // Request latch, beat counter, SRAM transfer registers and response registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rw_q       <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            k_q        <= 3'd0;
            rbuf_q     <= 16'h0;
            sram_rw    <= 1'b0;
            sram_addr  <= 32'h0;
            sram_dtw   <= 16'h0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            if (accept) begin
                rw_q    <= req_rw;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                k_q     <= 3'd0;
                if (req_bad) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= 32'h0;
                end else begin
                    sram_rw   <= req_rw;
                    sram_addr <= beat_addr(req_addr, req_rw, 3'd0);
                    sram_dtw  <= beat_dtw(req_rw, req_wdata, 3'd0);
                end
            end

            if (beat_done) begin
                k_q <= k_next;
                if (!rw_q && (k_q == 3'd0)) begin
                    rbuf_q <= sram_dtr;
                end
                if (last_beat) begin
                    resp_err   <= 1'b0;
                    resp_rdata <= rdata_final;
                end else begin
                    sram_addr <= beat_addr(addr_q, rw_q, k_next);
                    sram_dtw  <= beat_dtw(rw_q, wdata_q, k_next);
                end
            end

            // Response fields read as zero outside the response cycle.
            if (state_q == StResp) begin
                resp_err   <= 1'b0;
                resp_rdata <= 32'h0;
            end
        end
    end

endmodule
